hazard_stall_ctrl: RTL and testbench

Parametrised successor to the pipeline's load-use hazard detector. It sits beside the ID stage and drives the PC, IF/ID and ID/EX write enables and bubble controls. It adds three things: an optional no-forwarding mode, a multi-cycle EX-occupancy FSM for variable-latency ops (mul/div), and a saturating stall-cycle performance counter. The ID/EX control-zeroing output replaces the former control_op bubble signal.

---
 rtl/hazard_stall_ctrl.sv | 125 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller beside ID: load-use and no-forwarding RAW stalls,
// multi-cycle EX occupancy FSM and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
    parameter int REG_AW = 5,
    parameter int FWD_EN = 1,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_is_mc,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic              flush,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_write,
    output logic              id_ex_bubble,
    output logic              ex_mem_bubble,
    output logic              mc_busy,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int CW = $clog2(MC_LAT) + 1;
    localparam logic MC_ON = (MC_LAT >= 2);
    localparam logic [CW-1:0] CNT_INIT = (MC_LAT >= 2) ? CW'(MC_LAT - 2) : '0;

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic id_ex_bubble;
        logic ex_mem_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam ctrl_t CTRL_MC   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam ctrl_t CTRL_RAW  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            mc_stall;
    logic            ex_hit, mem_hit, raw_stall;
    ctrl_t           ctrl;

    // Register 0 is hardwired zero, so it can never carry a dependency.
    assign ex_hit  = (ex_rd != '0) &&
                     ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    assign mem_hit = (mem_rd != '0) &&
                     ((id_use_rs1 && id_rs1 == mem_rd) || (id_use_rs2 && id_rs2 == mem_rd));

    assign raw_stall = (FWD_EN != 0) ? (ex_mem_read && ex_hit)
                                     : ((ex_reg_write && ex_hit) || (mem_reg_write && mem_hit));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        mc_stall = 1'b0;
        case (state)
            IDLE: begin
                if (ex_is_mc && MC_ON) begin
                    mc_stall = 1'b1;
                    if (MC_LAT == 2) begin
                        state_n = DRAIN;
                    end else begin
                        state_n = BUSY;
                        cnt_n   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                mc_stall = 1'b1;
                if (cnt == CW'(1)) state_n = DRAIN;
                else               cnt_n   = cnt - CW'(1);
            end
            // The op leaves EX here; ex_is_mc still belongs to it, so ignore it.
            DRAIN:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are forced to the run pattern while reset is asserted.
    always_comb begin
        ctrl = CTRL_RUN;
        if (reset_n) begin
            if (mc_stall)       ctrl = CTRL_MC;
            else if (flush)     ctrl = CTRL_RUN;
            else if (raw_stall) ctrl = CTRL_RAW;
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign if_id_write   = ctrl.if_id_write;
    assign id_ex_write   = ctrl.id_ex_write;
    assign id_ex_bubble  = ctrl.id_ex_bubble;
    assign ex_mem_bubble = ctrl.ex_mem_bubble;
    assign mc_busy       = reset_n && (mc_stall || state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_cycles <= '0;
        else if (!pc_write && stall_cycles != '1)
            stall_cycles <= stall_cycles + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomized bench: three configurations share one stimulus stream and are
// checked against an occupancy-position reference model.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
    logic       id_use_rs1, id_use_rs2, ex_reg_write, ex_mem_read, ex_is_mc, mem_reg_write, flush;

    logic [2:0] pcw, ifw, idw, idb, emb, mcb;
    logic [31:0] sc_a;
    logic [3:0]  sc_b;
    logic [7:0]  sc_c;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.REG_AW(5), .FWD_EN(1), .MC_LAT(4), .CNT_W(32)) u_a (
        .clk(clk), .reset_n(reset_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_is_mc(ex_is_mc),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .flush(flush),
        .pc_write(pcw[0]), .if_id_write(ifw[0]), .id_ex_write(idw[0]),
        .id_ex_bubble(idb[0]), .ex_mem_bubble(emb[0]), .mc_busy(mcb[0]), .stall_cycles(sc_a));

    hazard_stall_ctrl #(.REG_AW(5), .FWD_EN(0), .MC_LAT(2), .CNT_W(4)) u_b (
        .clk(clk), .reset_n(reset_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_is_mc(ex_is_mc),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .flush(flush),
        .pc_write(pcw[1]), .if_id_write(ifw[1]), .id_ex_write(idw[1]),
        .id_ex_bubble(idb[1]), .ex_mem_bubble(emb[1]), .mc_busy(mcb[1]), .stall_cycles(sc_b));

    hazard_stall_ctrl #(.REG_AW(5), .FWD_EN(1), .MC_LAT(1), .CNT_W(8)) u_c (
        .clk(clk), .reset_n(reset_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_is_mc(ex_is_mc),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .flush(flush),
        .pc_write(pcw[2]), .if_id_write(ifw[2]), .id_ex_write(idw[2]),
        .id_ex_bubble(idb[2]), .ex_mem_bubble(emb[2]), .mc_busy(mcb[2]), .stall_cycles(sc_c));

    // Reference model: pos = cycles the current mc op has already spent in EX.
    int     fwd [3] = '{1, 0, 1};
    int     lat [3] = '{4, 2, 1};
    int     cw  [3] = '{32, 4, 8};
    int     pos [3];
    longint cnt [3];
    int     n_vec = 0;
    int     n_err = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit hit(input logic [4:0] r);
        return r != 0 && ((id_use_rs1 && id_rs1 == r) || (id_use_rs2 && id_rs2 == r));
    endfunction

    function automatic logic [5:0] obs(input int k);
        return {pcw[k], ifw[k], idw[k], idb[k], emb[k], mcb[k]};
    endfunction

    function automatic longint obs_cnt(input int k);
        return (k == 0) ? longint'(sc_a) : (k == 1) ? longint'(sc_b) : longint'(sc_c);
    endfunction

    // Expected {pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_mem_bubble, mc_busy}.
    function automatic logic [5:0] expect_out(input int k, output bit mcs);
        bit raw, drain;
        mcs   = (pos[k] == 0 && ex_is_mc && lat[k] >= 2) || (pos[k] >= 1 && pos[k] <= lat[k] - 2);
        drain = pos[k] >= 1 && pos[k] == lat[k] - 1;
        raw   = fwd[k] != 0 ? (ex_mem_read && hit(ex_rd))
                            : ((ex_reg_write && hit(ex_rd)) || (mem_reg_write && hit(mem_rd)));
        if (mcs)                return 6'b000011;
        else if (flush || !raw) return {5'b11100, drain};
        else                    return {5'b00110, drain};
    endfunction

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input bit u1, input bit u2,
                          input logic [4:0] erd, input bit ew, input bit el, input bit mc,
                          input logic [4:0] mrd, input bit mw, input bit fl);
        id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        ex_rd = erd; ex_reg_write = ew; ex_mem_read = el; ex_is_mc = mc;
        mem_rd = mrd; mem_reg_write = mw; flush = fl;
    endtask

    // Called just after a rising edge with inputs already applied.
    task automatic cyc(input bit do_rst);
        logic [5:0] e [3];
        bit         mcs [3];
        if (do_rst) begin
            #1 reset_n = 1'b0;
            #1;
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("rst_out%0d", k), longint'(obs(k)), 64'h38);
                chk($sformatf("rst_cnt%0d", k), obs_cnt(k), 0);
                pos[k] = 0;
                cnt[k] = 0;
            end
            #1 reset_n = 1'b1;
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            e[k] = expect_out(k, mcs[k]);
            chk($sformatf("out%0d", k), longint'(obs(k)), longint'(e[k]));
            chk($sformatf("cnt%0d", k), obs_cnt(k), cnt[k]);
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            pos[k] = mcs[k] ? pos[k] + 1 : 0;
            if (!e[k][5] && cnt[k] < ((64'd1 << cw[k]) - 1)) cnt[k]++;
        end
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        set_in(5, 5, 1, 1, 5, 1, 1, 1, 5, 1, 0);
        for (int k = 0; k < 3; k++) begin pos[k] = 0; cnt[k] = 0; end
        #12;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("init_out%0d", k), longint'(obs(k)), 64'h38);
            chk($sformatf("init_cnt%0d", k), obs_cnt(k), 0);
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // Load-use, zero register, unused source
        set_in(5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0); cyc(0);
        set_in(5, 0, 1, 0, 0, 0, 0, 0, 5, 1, 0); cyc(0);
        set_in(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0); cyc(0);
        set_in(5, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0); cyc(0);
        // No-forwarding RAW: EX hit then MEM hit then release
        set_in(0, 7, 0, 1, 7, 1, 0, 0, 0, 0, 0); cyc(0);
        set_in(0, 7, 0, 1, 0, 0, 0, 0, 7, 1, 0); cyc(0);
        set_in(0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0); cyc(0);
        // Multi-cycle op held high, with a load-use condition overlapping
        for (int i = 0; i < 8; i++) begin
            set_in(5, 0, 1, 0, 5, 1, i[0], 1, 0, 0, 0); cyc(0);
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc(0);
        // Flush beats load-use
        set_in(5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 1); cyc(0);
        // Reset in the BUSY phase
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0); cyc(0);
        cyc(0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc(1);
        cyc(0);
        // Sustained stall for saturation
        for (int i = 0; i < 20; i++) begin
            set_in(3, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0); cyc(0);
        end

        for (int i = 0; i < 1500; i++) begin
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                   5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 9) < 2,
                   5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom_range(0, 19) < 3);
            cyc($urandom_range(0, 99) < 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
